clock_timekeeper: RTL and testbench
===================================

Name: clock_timekeeper

Overview:
- Time-of-day core directly downstream of the divider stage.
- Takes the divider's slow square wave `tick_in`, resynchronises it into the `clk` domain and edge-detects it into a one-cycle advance pulse.
- Keeps hours:minutes:seconds in packed BCD; a small mode FSM lets the user set hours/minutes from two debounced buttons.
- Outputs feed the seven-segment display driver.

Parameters:
- SYNC_STAGES, 2, flops in the tick_in synchroniser (min 2).
- HOUR_MAX, 8'h23, last hour value in packed BCD before wrap to 8'h00.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tick_in  input  1  slow square wave from divider (asynchronous to use; only rising edges count).
- btn_mode  input  1  one-cycle pulse, already debounced; advances mode.
- btn_inc  input  1  one-cycle pulse, already debounced; increments selected field.
- hr_bcd  output  8  hours, packed BCD, 00..HOUR_MAX.
- min_bcd  output  8  minutes, packed BCD, 00..59.
- sec_bcd  output  8  seconds, packed BCD, 00..59.
- mode  output  3  current FSM state encoding.
- blink  output  1  display blink enable for the field being set.

Behaviour:
- Reset (async, rst=1): hr/min/sec = 8'h00, mode = RUN (3'd0), blink = 0, synchroniser and edge-history flops = 0. Reset mid-set-mode returns to RUN immediately.
- Tick path: tick_in goes through an SYNC_STAGES flop chain. tick_pulse = sync_last & ~prev, lasting one cycle.
  - With SYNC_STAGES=2, if tick_in is first sampled high at clk edge N, counters update at edge N+2.
  - A held-high tick_in gives exactly one pulse.
- Modes: RUN=0, SET_HR=1, SET_MIN=2.
  - btn_mode transitions: RUN->SET_HR->SET_MIN->RUN.
- RUN: each tick_pulse advances sec.
  - sec 59->00 carries to min; min 59->00 carries to hr; hr HOUR_MAX->00.
  - 23:59:59 -> 00:00:00 completes in a single cycle.
  - btn_inc is ignored.
- SET_HR / SET_MIN:
  - tick_pulse does not advance time; it only toggles blink.
  - btn_inc increments the selected field by 1 with wrap (hr HOUR_MAX->00, min 59->00), with no carry into other fields.
- Entering SET_HR clears sec to 00 on the same edge.
- Leaving to RUN clears blink to 0. blink is 0 whenever mode=RUN.
- BCD rule: ones digit 9->0 carries into the tens digit. Non-BCD values are unreachable; no recovery logic is required.
- Simultaneous events:
  - btn_mode + btn_inc in the same cycle: mode change only; inc is dropped.
  - btn_mode + tick_pulse in RUN: sec clear (entry to SET_HR) wins; the tick is dropped.
  - tick_pulse + btn_inc in a set mode: both apply (blink toggles, field increments).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLOCK_ALARM_EN.
- Defined:
  - Adds input alm_arm (1) and output alarm_out (1), plus internal alarm hr/min BCD registers (reset 8'h00).
  - Mode chain becomes RUN->SET_HR->SET_MIN->SET_AHR(3)->SET_AMIN(4)->RUN.
  - btn_inc in SET_AHR/SET_AMIN edits the alarm fields with the same wrap rules.
  - alarm_out is registered and equals alm_arm & (mode==RUN) & (hr==alm_hr) & (min==alm_min), so it stays high for one full minute. It is 0 at reset.
- Undefined: no alarm ports or registers; modes 3 and 4 are unreachable.

Decomposition:
- Package clock_pkg holds:
  - mode encodings RUN/SET_HR/SET_MIN/SET_AHR/SET_AMIN (3-bit);
  - BCD limit constants SEC_MAX=8'h59 and MIN_MAX=8'h59.
- Sub-module bcd_counter_2d:
  - 8-bit packed BCD, parameter MAX;
  - inputs inc and clr; outputs value and wrap (one-cycle, asserted when incrementing from MAX);
  - same async active-high rst.
- Instantiated for sec, min, hr, and, under the macro, the alarm fields.

Test Plan:
- Reset release, then 5 tick_in rising edges -> sec_bcd=8'h05, each update exactly 2 clk after first high sample; tick_in held high for 100 clk -> only one increment.
- Preload via set mode to 23:59, then 60 ticks in RUN -> 23:59:59 then 00:00:00 on a single edge.
- btn_mode x1 at sec=8'h37 -> mode=1, sec=8'h00; btn_inc x25 -> hr wraps 00..23..00 to 8'h01; ticks toggle blink, sec stays 00.
- btn_mode x2 from SET_HR -> SET_MIN then RUN, blink=0; btn_inc in RUN -> no change; btn_mode+btn_inc same cycle -> mode advances, field unchanged.
- rst pulsed while mode=2 and between sync stages -> all outputs 0, mode=0, no spurious increment after release with tick_in low.
- CLOCK_ALARM_EN: alarm set to 00:01, alm_arm=1, run 60 ticks -> alarm_out rises at min=8'h01 and falls at 8'h02; alm_arm=0 -> alarm_out stays 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day core: mode encodings, BCD limits
// and the packed-BCD increment used by every field counter.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_e;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // Next packed-BCD value: wrap to 00 after max, ones 9->0 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit packed-BCD counter with clear and wrap strobe.
// wrap is combinational so a carry chain of these settles within one edge.
module bcd_counter_2d
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Clear has priority over increment.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 8'h00;
    end else if (inc) begin
      value_d = bcd_inc(value_q, MAX);
    end
  end

  // Value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = inc & ~clr & (value_q == MAX);

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day core: resynchronises the divider tick, keeps hh:mm:ss in packed
// BCD and lets the user set hours/minutes through a small mode FSM.
// Optional alarm comparator is built when CLOCK_ALARM_EN is defined.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HOUR_MAX    = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
`ifdef CLOCK_ALARM_EN
  input  logic       alm_arm,
  output logic       alarm_out,
`endif
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [2:0] mode,
  output logic       blink
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  mode_e                  mode_q, mode_d;
  logic                   blink_q, blink_d;
  logic                   tick_pulse;
  logic                   is_run;
  logic                   edit_ok;

  logic sec_inc, sec_clr, sec_wrap;
  logic min_inc, min_wrap;
  logic hr_inc, hr_wrap;

  // Synchroniser shift and edge history.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign tick_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign is_run     = (mode_q == RUN);
  // A mode press in the same cycle swallows the increment.
  assign edit_ok    = btn_inc & ~btn_mode;

  // Mode next-state and blink control.
  always_comb begin
    mode_d  = mode_q;
    blink_d = blink_q;
    if (btn_mode) begin
      case (mode_q)
        RUN:      mode_d = SET_HR;
        SET_HR:   mode_d = SET_MIN;
`ifdef CLOCK_ALARM_EN
        SET_MIN:  mode_d = SET_AHR;
        SET_AHR:  mode_d = SET_AMIN;
`else
        SET_MIN:  mode_d = RUN;
`endif
        default:  mode_d = RUN;
      endcase
    end
    if (mode_d == RUN) begin
      blink_d = 1'b0;
    end else if (!is_run && tick_pulse) begin
      blink_d = ~blink_q;
    end
  end

  // Field strobes: ticks ripple seconds->minutes->hours in RUN; in set
  // modes only the selected field moves and nothing carries.
  assign sec_inc = is_run & tick_pulse & ~btn_mode;
  assign sec_clr = is_run & btn_mode;
  assign min_inc = is_run ? sec_wrap : ((mode_q == SET_MIN) & edit_ok);
  assign hr_inc  = is_run ? min_wrap : ((mode_q == SET_HR) & edit_ok);

  bcd_counter_2d #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .clr(sec_clr),
    .value(sec_bcd), .wrap(sec_wrap)
  );

  bcd_counter_2d #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
    .value(min_bcd), .wrap(min_wrap)
  );

  bcd_counter_2d #(.MAX(HOUR_MAX)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
    .value(hr_bcd), .wrap(hr_wrap)
  );

`ifdef CLOCK_ALARM_EN
  logic [7:0] alm_hr, alm_min;
  logic       alm_hr_wrap, alm_min_wrap;
  logic       alarm_q, alarm_d;

  bcd_counter_2d #(.MAX(HOUR_MAX)) u_alm_hr (
    .clk(clk), .rst(rst), .inc((mode_q == SET_AHR) & edit_ok), .clr(1'b0),
    .value(alm_hr), .wrap(alm_hr_wrap)
  );

  bcd_counter_2d #(.MAX(MIN_MAX)) u_alm_min (
    .clk(clk), .rst(rst), .inc((mode_q == SET_AMIN) & edit_ok), .clr(1'b0),
    .value(alm_min), .wrap(alm_min_wrap)
  );

  // Alarm match; held for the whole matching minute while armed in RUN.
  always_comb begin
    alarm_d = alm_arm & is_run & (hr_bcd == alm_hr) & (min_bcd == alm_min);
  end

  // Alarm output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_out = alarm_q;

  // Alarm fields never carry, so their wrap strobes have no consumer.
  logic unused_wraps;
  assign unused_wraps = &{1'b0, hr_wrap, alm_hr_wrap, alm_min_wrap};
`else
  // Day rollover has no consumer downstream.
  logic unused_wraps;
  assign unused_wraps = &{1'b0, hr_wrap};
`endif

  // Synchroniser, edge history, mode and blink registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      mode_q  <= RUN;
      blink_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      mode_q  <= mode_d;
      blink_q <= blink_d;
    end
  end

  assign mode  = mode_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: vector table, hand-written corner sequences
// and a randomized run against a seconds-of-day reference model.
// Alarm checks are included when CLOCK_ALARM_EN is defined.
module tb_clock_timekeeper;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hr_bcd, min_bcd, sec_bcd;
  logic [2:0] mode;
  logic       blink;
`ifdef CLOCK_ALARM_EN
  logic       alm_arm = 1'b0;
  logic       alarm_out;
`endif

  int total = 0;
  int bad = 0;

  clock_timekeeper #(.SYNC_STAGES(SYNC), .HOUR_MAX(8'h23)) dut (
    .clk(clk),
    .rst(rst),
    .tick_in(tick_in),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
`ifdef CLOCK_ALARM_EN
    .alm_arm(alm_arm),
    .alarm_out(alarm_out),
`endif
    .hr_bcd(hr_bcd),
    .min_bcd(min_bcd),
    .sec_bcd(sec_bcd),
    .mode(mode),
    .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference model: plain decimal time plus a history of tick_in samples.
  int m_h, m_m, m_s, m_mode;
  bit m_blink;
  bit hist[$];
`ifdef CLOCK_ALARM_EN
  int m_ah, m_am;
  bit m_alarm;
`endif

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int next_mode(input int md);
`ifdef CLOCK_ALARM_EN
    return (md == 4) ? 0 : md + 1;
`else
    return (md == 2) ? 0 : md + 1;
`endif
  endfunction

  function automatic void model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0;
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
`ifdef CLOCK_ALARM_EN
    m_ah = 0; m_am = 0; m_alarm = 0;
`endif
  endfunction

  // One clock edge of the model, using the inputs currently driven.
  function automatic void model_edge();
    bit pulse;
    int t, nm;
    // A rising edge first sampled SYNC edges ago acts on this edge.
    pulse = hist[SYNC-1] && !hist[SYNC];
    hist.push_front(tick_in);
    void'(hist.pop_back());
`ifdef CLOCK_ALARM_EN
    m_alarm = alm_arm && (m_mode == 0) && (m_h == m_ah) && (m_m == m_am);
`endif
    if (btn_mode) begin
      nm = next_mode(m_mode);
      if (m_mode == 0) m_s = 0;
      if (nm == 0) m_blink = 0;
      else if (m_mode != 0 && pulse) m_blink = !m_blink;
      m_mode = nm;
    end else if (m_mode == 0) begin
      if (pulse) begin
        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
      end
    end else begin
      if (pulse) m_blink = !m_blink;
      if (btn_inc) begin
        case (m_mode)
          1: m_h = (m_h + 1) % 24;
          2: m_m = (m_m + 1) % 60;
`ifdef CLOCK_ALARM_EN
          3: m_ah = (m_ah + 1) % 24;
          4: m_am = (m_am + 1) % 60;
`endif
          default: ;
        endcase
      end
    end
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, ".hr"}, hr_bcd, to_bcd(m_h));
    check8({tag, ".min"}, min_bcd, to_bcd(m_m));
    check8({tag, ".sec"}, sec_bcd, to_bcd(m_s));
    check8({tag, ".mode"}, {5'd0, mode}, 8'(m_mode));
    check8({tag, ".blink"}, {7'd0, blink}, {7'd0, m_blink});
`ifdef CLOCK_ALARM_EN
    check8({tag, ".alarm"}, {7'd0, alarm_out}, {7'd0, m_alarm});
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick_in = 0; btn_mode = 0; btn_inc = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic tick_once();
    tick_in = 1; step(); step();
    tick_in = 0; step(); step();
  endtask

  task automatic press_mode();
    btn_mode = 1; step(); btn_mode = 0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1; step();
    end
    btn_inc = 0;
  endtask

  typedef struct {
    bit         tick;
    bit         bm;
    bit         bi;
    logic [7:0] sec;
    logic [7:0] mn;
    logic [7:0] hr;
    logic [2:0] md;
    bit         blk;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0};
    vecs[1]  = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0};
    vecs[2]  = '{0, 0, 0, 8'h01, 8'h00, 8'h00, 3'd0, 0};
    vecs[3]  = '{0, 0, 0, 8'h01, 8'h00, 8'h00, 3'd0, 0};
    vecs[4]  = '{1, 0, 0, 8'h01, 8'h00, 8'h00, 3'd0, 0};
    vecs[5]  = '{1, 0, 0, 8'h01, 8'h00, 8'h00, 3'd0, 0};
    vecs[6]  = '{1, 0, 0, 8'h02, 8'h00, 8'h00, 3'd0, 0};
    vecs[7]  = '{1, 0, 0, 8'h02, 8'h00, 8'h00, 3'd0, 0};
    vecs[8]  = '{0, 1, 0, 8'h00, 8'h00, 8'h00, 3'd1, 0};
    vecs[9]  = '{0, 0, 1, 8'h00, 8'h00, 8'h01, 3'd1, 0};
    vecs[10] = '{0, 1, 1, 8'h00, 8'h00, 8'h01, 3'd2, 0};
    vecs[11] = '{0, 0, 1, 8'h00, 8'h01, 8'h01, 3'd2, 0};
    vecs[12] = '{0, 1, 0, 8'h00, 8'h01, 8'h01, 3'd0, 0};
    vecs[13] = '{0, 0, 1, 8'h00, 8'h01, 8'h01, 3'd0, 0};

    // Reset state.
    do_reset();
    check8("rst.hr", hr_bcd, 8'h00);
    check8("rst.min", min_bcd, 8'h00);
    check8("rst.sec", sec_bcd, 8'h00);
    check8("rst.mode", {5'd0, mode}, 8'd0);
    check8("rst.blink", {7'd0, blink}, 8'd0);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      tick_in = vecs[i].tick; btn_mode = vecs[i].bm; btn_inc = vecs[i].bi;
      step();
      check8($sformatf("vec%0d.sec", i), sec_bcd, vecs[i].sec);
      check8($sformatf("vec%0d.min", i), min_bcd, vecs[i].mn);
      check8($sformatf("vec%0d.hr", i), hr_bcd, vecs[i].hr);
      check8($sformatf("vec%0d.mode", i), {5'd0, mode}, {5'd0, vecs[i].md});
      check8($sformatf("vec%0d.blink", i), {7'd0, blink}, {7'd0, vecs[i].blk});
    end
    tick_in = 0; btn_mode = 0; btn_inc = 0;

    // Tick latency, held-high tick, five ticks.
    do_reset();
    tick_in = 1; step();
    check8("lat.n", sec_bcd, 8'h00);
    step();
    check8("lat.n1", sec_bcd, 8'h00);
    step();
    check8("lat.n2", sec_bcd, 8'h01);
    for (int i = 0; i < 100; i++) step();
    check8("held.sec", sec_bcd, 8'h01);
    tick_in = 0; step(); step(); step();
    for (int i = 0; i < 4; i++) tick_once();
    check8("five.sec", sec_bcd, 8'h05);

    // Preload 23:59 and roll the day over.
    do_reset();
    press_mode(); press_inc(23); press_mode(); press_inc(59); press_mode();
    check8("pre.hr", hr_bcd, 8'h23);
    check8("pre.min", min_bcd, 8'h59);
    check8("pre.mode", {5'd0, mode}, 8'd0);
    for (int i = 0; i < 59; i++) tick_once();
    check8("roll.sec59", sec_bcd, 8'h59);
    tick_in = 1; step(); step(); tick_in = 0;
    check8("roll.before", {hr_bcd, min_bcd, sec_bcd} == 24'h235959 ? 8'd1 : 8'd0, 8'd1);
    step();
    check8("roll.hr", hr_bcd, 8'h00);
    check8("roll.min", min_bcd, 8'h00);
    check8("roll.sec", sec_bcd, 8'h00);
    step();

    // Enter SET_HR at sec=37, hour wrap, blink on ticks.
    for (int i = 0; i < 37; i++) tick_once();
    check8("s37.sec", sec_bcd, 8'h37);
    press_mode();
    check8("sethr.mode", {5'd0, mode}, 8'd1);
    check8("sethr.sec", sec_bcd, 8'h00);
    press_inc(25);
    check8("sethr.hr", hr_bcd, 8'h01);
    tick_once();
    check8("blink.on", {7'd0, blink}, 8'd1);
    check8("blink.sec", sec_bcd, 8'h00);
    tick_once();
    check8("blink.off", {7'd0, blink}, 8'd0);

    // Back to RUN, inc ignored, mode+inc together.
    press_mode();
    check8("setmin.mode", {5'd0, mode}, 8'd2);
    tick_once();
    check8("setmin.blink", {7'd0, blink}, 8'd1);
    press_mode();
`ifdef CLOCK_ALARM_EN
    press_mode(); press_mode();
`endif
    check8("run.mode", {5'd0, mode}, 8'd0);
    check8("run.blink", {7'd0, blink}, 8'd0);
    press_inc(1);
    check8("runinc.hr", hr_bcd, 8'h01);
    check8("runinc.min", min_bcd, 8'h00);
    btn_mode = 1; btn_inc = 1; step(); btn_mode = 0; btn_inc = 0;
    check8("both.mode", {5'd0, mode}, 8'd1);
    check8("both.hr", hr_bcd, 8'h01);

    // Asynchronous reset in SET_MIN with a tick half-way through the synchroniser.
    press_mode();
    tick_in = 1; step(); tick_in = 0;
    #2 rst = 1;
    #1;
    check8("arst.hr", hr_bcd, 8'h00);
    check8("arst.mode", {5'd0, mode}, 8'd0);
    check8("arst.blink", {7'd0, blink}, 8'd0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 10; i++) step();
    check8("arst.sec", sec_bcd, 8'h00);
    check8("arst.min", min_bcd, 8'h00);

`ifdef CLOCK_ALARM_EN
    // Alarm at 00:01: high for that minute only, and only when armed.
    do_reset();
    press_mode(); press_mode(); press_mode(); press_mode();
    press_inc(1);
    press_mode();
    alm_arm = 1;
    step();
    check8("alm.pre", {7'd0, alarm_out}, 8'd0);
    for (int i = 0; i < 60; i++) tick_once();
    check8("alm.min", min_bcd, 8'h01);
    check8("alm.on", {7'd0, alarm_out}, 8'd1);
    alm_arm = 0; step(); step();
    check8("alm.disarm", {7'd0, alarm_out}, 8'd0);
    alm_arm = 1; step(); step();
    check8("alm.rearm", {7'd0, alarm_out}, 8'd1);
    for (int i = 0; i < 60; i++) tick_once();
    check8("alm.min2", min_bcd, 8'h02);
    check8("alm.off", {7'd0, alarm_out}, 8'd0);
`endif

    // Randomized run against the model.
    do_reset();
    press_mode(); press_inc(23); press_mode(); press_inc(58); press_mode();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
      btn_mode = ($urandom_range(0, 19) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
`ifdef CLOCK_ALARM_EN
      if ($urandom_range(0, 49) == 0) alm_arm = ~alm_arm;
`endif
      step();
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
